// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory controller: access sizes,
// controller states and boolean constants.
package mem_ctrl_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            SIZE_WORD: return 3'd4;
            default:   return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetch and load/store
// onto an 8-bit RAM port. Define IO_STALL_EN to hold I/O stores while io_buffer_full.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter logic [31:0] IO_ADDR_HI = 32'h0003_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_wr,
    input  logic [1:0]  ls_size,
    input  logic        ls_sext,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_grant,
    output logic        ls_valid,
    output logic [31:0] ls_rdata,
    output logic        store_done,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    state_e      state;
    logic [2:0]  cnt;
    logic [2:0]  nbytes;
    logic [31:0] base;
    logic [31:0] wdata;
    logic [31:0] rbuf;
    logic [1:0]  rsize;
    logic        rsext;
    logic        is_fetch;

    logic [2:0]  step;
    logic [2:0]  wr_idx;
    logic [1:0]  cap_idx;
    logic [31:0] rd_word;
    logic [31:0] wr_addr;
    logic        acc_stall;
    logic        wr_stall;
    logic        pulse_busy;

    function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                                input logic [1:0]  size,
                                                input logic        sext);
        case (size)
            SIZE_BYTE: return {{24{sext & raw[7]}}, raw[7:0]};
            SIZE_HALF: return {{16{sext & raw[15]}}, raw[15:0]};
            default:   return raw;
        endcase
    endfunction

    // cnt counts edges since acceptance; a read byte arrives two edges after its address
    assign step       = cnt + 3'd1;
    assign cap_idx    = 2'(cnt - 3'd1);
    assign wr_idx     = mem_wr ? step : cnt;
    assign wr_addr    = base + 32'(wr_idx);
    assign pulse_busy = if_valid | ls_valid | store_done;

    always_comb begin
        rd_word = rbuf;
        rd_word[{cap_idx, 3'b000} +: 8] = mem_din;
    end

`ifdef IO_STALL_EN
    assign acc_stall = io_buffer_full && (ls_addr >= IO_ADDR_HI);
    assign wr_stall  = io_buffer_full && (wr_addr >= IO_ADDR_HI);
`else
    logic unused_io_full;
    assign unused_io_full = io_buffer_full;
    assign acc_stall      = FALSE;
    assign wr_stall       = FALSE;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            nbytes     <= '0;
            base       <= '0;
            wdata      <= '0;
            rbuf       <= '0;
            rsize      <= '0;
            rsext      <= FALSE;
            is_fetch   <= FALSE;
            if_valid   <= FALSE;
            if_data    <= '0;
            ls_grant   <= FALSE;
            ls_valid   <= FALSE;
            ls_rdata   <= '0;
            store_done <= FALSE;
            mem_dout   <= '0;
            mem_a      <= '0;
            mem_wr     <= FALSE;
        end else if (rdy) begin
            if_valid   <= FALSE;
            ls_valid   <= FALSE;
            ls_grant   <= FALSE;
            store_done <= FALSE;
            case (state)
                IDLE: begin
                    mem_wr <= FALSE;
                    mem_a  <= '0;
                    cnt    <= '0;
                    // hold off while the previous completion pulse is still visible
                    if (!pulse_busy) begin
                        if (ls_req && ls_wr) begin
                            state    <= WRITE;
                            ls_grant <= TRUE;
                            base     <= ls_addr;
                            wdata    <= ls_wdata;
                            nbytes   <= size_bytes(ls_size);
                            mem_a    <= ls_addr;
                            mem_dout <= ls_wdata[7:0];
                            mem_wr   <= !acc_stall;
                        end else if (ls_req && !rollback) begin
                            state    <= READ;
                            ls_grant <= TRUE;
                            base     <= ls_addr;
                            nbytes   <= size_bytes(ls_size);
                            rsize    <= ls_size;
                            rsext    <= ls_sext;
                            is_fetch <= FALSE;
                            rbuf     <= '0;
                            mem_a    <= ls_addr;
                        end else if (if_req && !rollback) begin
                            state    <= READ;
                            base     <= if_addr;
                            nbytes   <= 3'd4;
                            rsize    <= SIZE_WORD;
                            rsext    <= FALSE;
                            is_fetch <= TRUE;
                            rbuf     <= '0;
                            mem_a    <= if_addr;
                        end
                    end
                end
                READ: begin
                    if (rollback) begin
                        state <= IDLE;
                        mem_a <= '0;
                        rbuf  <= '0;
                        cnt   <= '0;
                    end else begin
                        if (step < nbytes)
                            mem_a <= base + 32'(step);
                        if (step >= 3'd2)
                            rbuf <= rd_word;
                        if (step == nbytes + 3'd1) begin
                            state <= IDLE;
                            mem_a <= '0;
                            if (is_fetch) begin
                                if_valid <= TRUE;
                                if_data  <= rd_word;
                            end else begin
                                ls_valid <= TRUE;
                                ls_rdata <= load_extend(rd_word, rsize, rsext);
                            end
                        end
                        cnt <= step;
                    end
                end
                WRITE: begin
                    // a stalled byte (mem_wr low) is retried at the same index
                    if (mem_wr && step == nbytes) begin
                        state      <= IDLE;
                        mem_wr     <= FALSE;
                        mem_a      <= '0;
                        cnt        <= '0;
                        store_done <= TRUE;
                    end else begin
                        cnt      <= wr_idx;
                        mem_a    <= wr_addr;
                        mem_dout <= wdata[{wr_idx[1:0], 3'b000} +: 8];
                        mem_wr   <= !wr_stall;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Randomized bench for mem_ctrl with a byte-addressed reference memory model.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        rollback;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_valid;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_wr;
    logic [1:0]  ls_size;
    logic        ls_sext;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_grant;
    logic        ls_valid;
    logic [31:0] ls_rdata;
    logic        store_done;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] a0, a1, wa0;
    logic [7:0]  wd0;

`ifdef IO_STALL_EN
    localparam int STALL = 3;
`else
    localparam int STALL = 0;
`endif

    logic [7:0] ram [0:262143];
    logic [7:0] mdl [logic [31:0]];

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_data(if_data),
        .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_sext(ls_sext),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_grant(ls_grant),
        .ls_valid(ls_valid), .ls_rdata(ls_rdata), .store_done(store_done),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    // RAM with one cycle of read latency, paused together with the controller
    always @(posedge clk) begin
        if (rdy) begin
            if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
            mem_din <= ram[mem_a[17:0]];
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time exceeded, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int nb(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [7:0] mdl_rd(input logic [31:0] a);
        return mdl.exists(a) ? mdl[a] : 8'h00;
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] a, input int n, input bit sext);
        longint v = 0;
        for (int i = 0; i < n; i++)
            v += longint'(mdl_rd(a + 32'(i))) << (8 * i);
        if (sext && v >= (longint'(1) << (8 * n - 1)))
            v -= longint'(1) << (8 * n);
        return 32'(v);
    endfunction

    task automatic run_read(input bit fetch, input logic [31:0] addr, input logic [1:0] size,
                            input bit sext, input int pause,
                            output logic [31:0] data, output int lat);
        logic [31:0] a_frz;
        bit frz_ok;
        int gcyc;
        data = '0; lat = 0; frz_ok = 1; gcyc = 0; a_frz = '0;
        if (fetch) begin
            if_addr = addr; if_req = 1'b1;
        end else begin
            ls_wr = 1'b0; ls_size = size; ls_sext = sext; ls_addr = addr; ls_req = 1'b1;
        end
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                a0 = mem_a; a_frz = mem_a;
                if (pause > 0) rdy = 1'b0;
            end
            if (c == 2) a1 = mem_a;
            if (c >= 2 && c <= pause + 1 && mem_a !== a_frz) frz_ok = 0;
            if (c == pause + 1) rdy = 1'b1;
            if (ls_grant && gcyc == 0) gcyc = c;
            if (fetch ? if_valid : ls_valid) begin
                data = fetch ? if_data : ls_rdata;
                lat = c;
                break;
            end
        end
        if_req = 1'b0; ls_req = 1'b0; rdy = 1'b1;
        chk("rd_timeout", 32'(lat != 0), 32'd1);
        if (!fetch) chk("ls_grant_cyc", gcyc, 1);
        if (pause > 0) chk("rdy_freeze", 32'(frz_ok), 32'd1);
        @(posedge clk); #1;
        chk("valid_pulse", 32'(if_valid | ls_valid), 32'd0);
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd,
                             input int rb_cyc, input int full_cyc,
                             output int lat, output int wcount, output int first_wr);
        int n;
        n = nb(size);
        lat = 0; wcount = 0; first_wr = 0;
        ls_wr = 1'b1; ls_size = size; ls_addr = addr; ls_wdata = wd; ls_sext = 1'b0;
        rollback = (rb_cyc > 0); io_buffer_full = (full_cyc > 0);
        ls_req = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (mem_wr) begin
                wcount++;
                if (first_wr == 0) begin first_wr = c; wa0 = mem_a; wd0 = mem_dout; end
            end
            if (c == rb_cyc) rollback = 1'b0;
            if (c == full_cyc) io_buffer_full = 1'b0;
            if (store_done) begin lat = c; break; end
        end
        ls_req = 1'b0; ls_wr = 1'b0; rollback = 1'b0; io_buffer_full = 1'b0;
        chk("st_timeout", 32'(lat != 0), 32'd1);
        @(posedge clk); #1;
        chk("done_pulse", 32'(store_done), 32'd0);
        for (int i = 0; i < n; i++) begin
            mdl[addr + 32'(i)] = 8'((wd >> (8 * i)) & 32'hFF);
            chk("st_byte", 32'(ram[18'(addr + 32'(i))]), 32'(mdl_rd(addr + 32'(i))));
        end
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd);
        int lat, wc, fw;
        run_write(addr, size, wd, 0, 0, lat, wc, fw);
        chk("st_lat", lat, nb(size) + 1);
        chk("st_wcnt", wc, nb(size));
    endtask

    task automatic do_load(input bit fetch, input logic [31:0] addr, input logic [1:0] size, input bit sext);
        logic [31:0] d, e;
        int lat, n;
        n = fetch ? 4 : nb(size);
        e = exp_load(addr, n, fetch ? 1'b0 : sext);
        run_read(fetch, addr, size, sext, 0, d, lat);
        chk(fetch ? "fetch_data" : "load_data", d, e);
        chk("rd_lat", lat, n + 2);
    endtask

    initial begin
        logic [31:0] d, ldata, idata;
        int lat, wc, fw, lv, iv, gcyc, cnt;

        rst = 1'b0; rdy = 1'b1; rollback = 1'b0; if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_wr = 1'b0; ls_size = '0; ls_sext = 1'b0; ls_addr = '0;
        ls_wdata = '0; io_buffer_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_dout", 32'(mem_dout), 32'd0);
        chk("rst_pulses", {28'd0, if_valid, ls_valid, ls_grant, store_done}, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_ls_rdata", ls_rdata, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_mem_a", mem_a, 32'd0);

        // instruction fetch of a known word
        do_store(32'h100, 2'd2, 32'h0000_0013);
        run_read(1'b1, 32'h100, 2'd2, 1'b0, 0, d, lat);
        chk("fetch_0x100", d, 32'h0000_0013);
        chk("fetch_lat", lat, 6);

        // halfword load wrapping past the top of the address space
        do_store(32'hFFFF_FFFF, 2'd0, 32'h0000_00FE);
        do_store(32'h0000_0000, 2'd0, 32'h0000_00FF);
        run_read(1'b0, 32'hFFFF_FFFF, 2'd1, 1'b1, 0, d, lat);
        chk("wrap_a0", a0, 32'hFFFF_FFFF);
        chk("wrap_a1", a1, 32'h0000_0000);
        chk("wrap_lh_sext", d, 32'hFFFF_FFFE);
        chk("wrap_lat", lat, 4);
        do_load(1'b0, 32'hFFFF_FFFF, 2'd1, 1'b0);

        // load/store has priority over fetch
        do_store(32'h200, 2'd2, 32'h8BAD_F00D);
        ls_wr = 1'b0; ls_size = 2'd2; ls_sext = 1'b0; ls_addr = 32'h200; ls_req = 1'b1;
        if_addr = 32'h100; if_req = 1'b1;
        lv = 0; iv = 0; gcyc = 0; ldata = '0; idata = '0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (ls_grant && gcyc == 0) gcyc = c;
            if (ls_valid) begin lv = c; ldata = ls_rdata; ls_req = 1'b0; end
            if (if_valid) begin iv = c; idata = if_data; break; end
        end
        if_req = 1'b0; ls_req = 1'b0;
        chk("prio_grant", gcyc, 1);
        chk("prio_ls_lat", lv, 6);
        chk("prio_ls_data", ldata, 32'h8BAD_F00D);
        chk("prio_if_after", 32'(iv > lv), 32'd1);
        chk("prio_if_data", idata, 32'h0000_0013);
        @(posedge clk); #1;

        // pause with rdy low in the middle of a load
        run_read(1'b0, 32'h200, 2'd2, 1'b0, 3, d, lat);
        chk("pause_data", d, 32'h8BAD_F00D);
        chk("pause_lat", lat, 9);

        // rollback two cycles into a fetch, held while a fetch request is pending
        if_addr = 32'h100; if_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("fetch_a_k1", mem_a, 32'h101);
        rollback = 1'b1;
        @(posedge clk); #1;
        chk("rb_idle", mem_a, 32'd0);
        cnt = int'(if_valid);
        @(posedge clk); #1;
        chk("rb_noaccept", mem_a, 32'd0);
        cnt += int'(if_valid);
        rollback = 1'b0; if_req = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            cnt += int'(if_valid);
        end
        chk("rb_no_valid", cnt, 0);

        // rollback coincident with and during a word store
        run_write(32'h300, 2'd2, 32'hCAFE_BABE, 3, 0, lat, wc, fw);
        chk("rb_st_lat", lat, 5);
        chk("rb_st_wcnt", wc, 4);

        // store to the I/O window while the I/O buffer reports full
        run_write(32'h0003_0000, 2'd0, 32'h0000_0041, 0, 3, lat, wc, fw);
        chk("io_first_wr", fw, 1 + STALL);
        chk("io_wcnt", wc, 1);
        chk("io_lat", lat, 2 + STALL);
        chk("io_addr", wa0, 32'h0003_0000);
        chk("io_data", 32'(wd0), 32'h41);

        // random traffic over a preloaded window
        for (logic [31:0] a = 32'h2000; a < 32'h2048; a += 32'd4)
            do_store(a, 2'd2, $urandom);
        for (int t = 0; t < 40; t++) begin
            int op;
            logic [31:0] ra;
            logic [1:0]  rs;
            op = $urandom_range(0, 2);
            ra = 32'h2000 + 32'($urandom_range(0, 63));
            rs = 2'($urandom_range(0, 2));
            case (op)
                0: do_load(1'b1, ra, 2'd2, 1'b0);
                1: do_load(1'b0, ra, rs, 1'($urandom_range(0, 1)));
                default: do_store(ra, rs, $urandom);
            endcase
        end

        // reset in the middle of a word store
        ls_wr = 1'b1; ls_size = 2'd2; ls_addr = 32'h5000; ls_wdata = 32'h1122_3344; ls_req = 1'b1;
        @(posedge clk); #1;
        chk("mid_wr_active", 32'(mem_wr), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; ls_req = 1'b0; ls_wr = 1'b0;
        #1;
        chk("async_rst_wr", 32'(mem_wr), 32'd0);
        chk("async_rst_a", mem_a, 32'd0);
        chk("async_rst_dout", 32'(mem_dout), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(posedge clk); #1;
            cnt += int'(store_done);
        end
        chk("rst_no_done", cnt, 0);
        do_load(1'b1, 32'h100, 2'd2, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
